decoder_2: RTL and testbench
============================

Name: decoder_2

Overview:
- Registered binary-to-one-hot decoder with enable: N-bit select in, OUT_W-bit one-hot word out.
- Default configuration is a 3-to-8 decoder, used wherever a one-hot select or strobe must be derived from a binary index.
- Output is registered on the single clock domain, giving one cycle of latency.
- Also flags out-of-range selects and reports whether the output is valid.

Parameters:
- IN_W, 3, width of select input x; legal range 1..6.
- OUT_W, 8, number of decoded outputs; must satisfy 1 <= OUT_W <= 2**IN_W.
- ACT_LOW, 0, when 1 the D output is inverted (active-low one-hot: selected bit 0, others 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  decode enable, sampled on clk.
- x  input  IN_W  binary select index, sampled on clk.
- D  output  OUT_W  registered one-hot (or one-cold if ACT_LOW=1) decode.
- vld  output  1  registered; 1 when D holds a valid one-hot selection.
- err  output  1  registered; 1 when en=1 and x >= OUT_W was sampled.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - D = all inactive (0s if ACT_LOW=0, 1s if ACT_LOW=1).
  - vld = 0, err = 0.
- Deassertion of rst_n is taken synchronously by the flops; first update occurs on the first rising clk with rst_n=1.
- Each rising clk with rst_n=1, registers load from en and x sampled at that edge:
  - en=1 and x < OUT_W: D[x] active, all other bits inactive; vld=1; err=0.
  - en=1 and x >= OUT_W (only possible when OUT_W < 2**IN_W): D all inactive; vld=0; err=1.
  - en=0: D all inactive; vld=0; err=0, regardless of x.
- Latency: exactly 1 clk from the en/x change (meeting setup) to D/vld/err.
- No hold behaviour: outputs follow inputs every cycle; a single-cycle en pulse gives a single-cycle D pulse.
- At most one D bit is active in any cycle, including reset and the err condition.
- x or en containing X/Z: no requirement beyond simulation; the bench must drive known values after reset.
- Reset asserted mid-operation: outputs return to the reset state immediately without waiting for clk.
- ACT_LOW affects D only; vld and err are always active-high.
- Select width: x is compared as an unsigned value; no truncation to log2(OUT_W) bits.
- Elaboration must fail (generate-time check) if OUT_W > 2**IN_W or OUT_W < 1.

Optional Feature:
- Macro DECODER_2_HITCNT_EN.
- When defined, the block adds:
  - Output port hit_cnt of width 16.
  - Output port hit_ovf of width 1.
- hit_cnt increments by 1 on every clk where the registered vld transitions to or stays 1, i.e. each valid decode cycle.
- hit_cnt saturates at 16'hFFFF, and hit_ovf sets sticky to 1 at saturation.
- Both clear to 0 on rst_n=0.
- When the macro is not defined, the two ports and all counter logic are absent; remaining behaviour is identical.

Test Plan:
- Reset: rst_n=0 with en=1, x=3, clock running -> D=8'h00, vld=0, err=0 throughout; release rst_n -> next edge D=8'h08, vld=1.
- Disabled: rst_n=1, en=0, x stepped 3,4,5,0 one per cycle -> D=8'h00, vld=0, err=0 every cycle.
- Full sweep: en=1, x=0..7 one per cycle -> one cycle later D = 8'h01, 02, 04, 08, 10, 20, 40, 80 in order; vld=1 every cycle.
- Enable toggle: en=1, x=5 for 1 cycle, then en=0 -> D=8'h20 for exactly one cycle, then 8'h00.
- Out of range: IN_W=3, OUT_W=6, en=1, x=6 -> D=6'b000000, vld=0, err=1.
- Out of range, legal select: same configuration, x=5 -> D=6'b100000, err=0.
- Async reset and ACT_LOW:
  - With ACT_LOW=1, x=2, en=1 -> D=8'hFB.
  - Assert rst_n=0 between clock edges -> D=8'hFF immediately, vld=0.
- Optional (DECODER_2_HITCNT_EN defined): 10 valid decode cycles then en=0 -> hit_cnt=10, hit_ovf=0.

Source files
------------

// File: rtl/decoder_2.sv
// Registered binary-to-one-hot decoder with enable, out-of-range flag and valid flag.
// Optional valid-decode hit counter when DECODER_2_HITCNT_EN is defined.
module decoder_2 #(
  parameter int IN_W    = 3,
  parameter int OUT_W   = 8,
  parameter bit ACT_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] D,
  output logic             vld,
  output logic             err
`ifdef DECODER_2_HITCNT_EN
  ,
  output logic [15:0]      hit_cnt,
  output logic             hit_ovf
`endif
);

  if (IN_W < 1 || IN_W > 6) begin : g_bad_in_w
    $error("decoder_2: IN_W must be in 1..6");
  end
  if (OUT_W < 1 || OUT_W > (1 << IN_W)) begin : g_bad_out_w
    $error("decoder_2: OUT_W must satisfy 1 <= OUT_W <= 2**IN_W");
  end

  // XOR mask that turns the active-high one-hot word into the output polarity
  localparam logic [OUT_W-1:0] D_IDLE = {OUT_W{ACT_LOW}};

  logic [31:0]      x_ext;
  logic             in_range;
  logic [OUT_W-1:0] hot;
  logic             vld_nxt;
  logic             err_nxt;

  assign x_ext = 32'(x);

  always_comb begin
    in_range = (x_ext < 32'(OUT_W));
    hot      = '0;
    for (int i = 0; i < OUT_W; i++) begin
      hot[i] = en && (x_ext == 32'(i));
    end
    vld_nxt  = en && in_range;
    err_nxt  = en && !in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D   <= D_IDLE;
      vld <= 1'b0;
      err <= 1'b0;
    end else begin
      D   <= hot ^ D_IDLE;
      vld <= vld_nxt;
      err <= err_nxt;
    end
  end

`ifdef DECODER_2_HITCNT_EN
  // Counts edges that load vld=1; overflow flag latches once the count pins at max
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= 16'h0000;
      hit_ovf <= 1'b0;
    end else if (vld_nxt && hit_cnt != 16'hFFFF) begin
      hit_cnt <= hit_cnt + 16'h0001;
      if (hit_cnt == 16'hFFFE) begin
        hit_ovf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_decoder_2.sv
// Self-checking bench for decoder_2: three configurations (3:8, 3:6, 3:8 active-low)
// checked every cycle against an arithmetic model plus literal expectations.
module tb_decoder_2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [2:0] x = 3'd0;
  bit         mon_on = 1'b0;

  logic [7:0] d8, da;
  logic [5:0] d6;
  logic       v8, e8, v6, e6, va, ea;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef DECODER_2_HITCNT_EN
  logic [15:0] hc8, hc6, hca;
  logic        ho8, ho6, hoa;
`endif

  decoder_2 #(.IN_W(3), .OUT_W(8), .ACT_LOW(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .D(d8), .vld(v8), .err(e8)
`ifdef DECODER_2_HITCNT_EN
    , .hit_cnt(hc8), .hit_ovf(ho8)
`endif
  );

  decoder_2 #(.IN_W(3), .OUT_W(6), .ACT_LOW(1'b0)) u6 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .D(d6), .vld(v6), .err(e6)
`ifdef DECODER_2_HITCNT_EN
    , .hit_cnt(hc6), .hit_ovf(ho6)
`endif
  );

  decoder_2 #(.IN_W(3), .OUT_W(8), .ACT_LOW(1'b1)) ua (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .D(da), .vld(va), .err(ea)
`ifdef DECODER_2_HITCNT_EN
    , .hit_cnt(hca), .hit_ovf(hoa)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Expected D: the selected bit is 2**x when enabled and in range, else nothing
  function automatic int exp_d(input bit e, input int xi, input int ow, input bit al);
    int v;
    v = (e && xi < ow) ? (1 << xi) : 0;
    if (al) v = ~v & ((1 << ow) - 1);
    return v;
  endfunction

  logic [7:0] m_d8, m_da;
  logic [5:0] m_d6;
  bit         m_v8, m_e8, m_v6, m_e6, m_va, m_ea;
  int         m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d8 = 8'h00; m_d6 = 6'h00; m_da = 8'hFF;
      {m_v8, m_e8, m_v6, m_e6, m_va, m_ea} = '0;
      m_cnt = 0;
    end else begin
      m_d8 = 8'(exp_d(en, int'(x), 8, 1'b0));
      m_d6 = 6'(exp_d(en, int'(x), 6, 1'b0));
      m_da = 8'(exp_d(en, int'(x), 8, 1'b1));
      m_v8 = en && (int'(x) < 8);  m_e8 = en && (int'(x) >= 8);
      m_v6 = en && (int'(x) < 6);  m_e6 = en && (int'(x) >= 6);
      m_va = m_v8;                 m_ea = m_e8;
      if (m_v8 && m_cnt < 65535) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("u8_D",   32'(d8), 32'(m_d8));
      chk("u8_vld", 32'(v8), 32'(m_v8));
      chk("u8_err", 32'(e8), 32'(m_e8));
      chk("u6_D",   32'(d6), 32'(m_d6));
      chk("u6_vld", 32'(v6), 32'(m_v6));
      chk("u6_err", 32'(e6), 32'(m_e6));
      chk("ua_D",   32'(da), 32'(m_da));
      chk("ua_vld", 32'(va), 32'(m_va));
      chk("ua_err", 32'(ea), 32'(m_ea));
`ifdef DECODER_2_HITCNT_EN
      chk("u8_hit_cnt", 32'(hc8), 32'(m_cnt));
      chk("u8_hit_ovf", 32'(ho8), 32'(m_cnt == 65535));
`endif
    end
  end

  task automatic drive(input bit e, input int xi);
    en = e;
    x  = 3'(xi);
    @(negedge clk);
  endtask

  localparam logic [7:0] SWEEP [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  localparam int         DIS_X [4] = '{3, 4, 5, 0};

  initial begin
    #1 rst_n = 1'b0;
    mon_on = 1'b1;

    // reset held with a live request
    en = 1'b1; x = 3'd3;
    repeat (3) begin
      @(negedge clk);
      chk("rst_D", 32'(d8), 32'h00);
      chk("rst_vld", 32'(v8), 32'h0);
      chk("rst_err", 32'(e8), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_D", 32'(d8), 32'h08);
    chk("rel_vld", 32'(v8), 32'h1);

    foreach (DIS_X[i]) begin
      drive(1'b0, DIS_X[i]);
      chk("dis_D", 32'(d8), 32'h00);
      chk("dis_vld", 32'(v8), 32'h0);
    end

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i);
      chk("sweep_D", 32'(d8), 32'(SWEEP[i]));
      chk("sweep_vld", 32'(v8), 32'h1);
    end

    drive(1'b1, 5);
    chk("pulse_D", 32'(d8), 32'h20);
    drive(1'b0, 5);
    chk("pulse_off_D", 32'(d8), 32'h00);

    drive(1'b1, 6);
    chk("oor_D", 32'(d6), 32'h00);
    chk("oor_vld", 32'(v6), 32'h0);
    chk("oor_err", 32'(e6), 32'h1);
    chk("oor_wide_D", 32'(d8), 32'h40);
    drive(1'b1, 7);
    chk("oor7_err", 32'(e6), 32'h1);
    drive(1'b1, 5);
    chk("legal5_D", 32'(d6), 32'h20);
    chk("legal5_err", 32'(e6), 32'h0);

    drive(1'b1, 2);
    chk("al_D", 32'(da), 32'hFB);
    chk("al_vld", 32'(va), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_al_D", 32'(da), 32'hFF);
    chk("async_al_vld", 32'(va), 32'h0);
    chk("async_D", 32'(d8), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 0);

`ifdef DECODER_2_HITCNT_EN
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) drive(1'b1, i % 8);
    drive(1'b0, 0);
    chk("hit_cnt10", 32'(hc8), 32'd10);
    chk("hit_ovf0", 32'(ho8), 32'h0);
`endif

    drive(1'b0, 0);
    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
